// File: rtl/temp_level_monitor_pkg.sv
// Shared level encoding for the temperature level monitor and its per-channel FSM.
// The level values are ordered, so "higher level" comparisons can be made on the raw code.
package temp_level_monitor_pkg;

    typedef enum logic [1:0] {
        LVL_NORMAL   = 2'd0,
        LVL_PREVENT  = 2'd1,
        LVL_CRITICAL = 2'd2
    } level_t;

    function automatic logic is_alert(input level_t lvl);
        return (lvl != LVL_NORMAL);
    endfunction

endpackage

// File: rtl/temp_level_channel.sv
// One sensor channel: hysteretic level classification plus a persistence filter
// that only commits a level change after PERSIST consecutive matching samples.
module temp_level_channel
    import temp_level_monitor_pkg::*;
#(
    parameter int          W       = 5,
    parameter int          PERSIST = 3,
    parameter int unsigned HYST    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_valid,
    input  logic [W-1:0] temp,
    input  logic [W-1:0] prevent_thr,
    input  logic [W-1:0] critical_thr,
    output logic         prevent,
    output logic         critical,
    output logic         in_critical,
    output logic         entering_critical
);

    localparam int            CW      = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST);

    level_t        state_reg, state_next;
    level_t        pending_reg, pending_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          prevent_reg, critical_reg;

    logic [W-1:0]  eff_prev, eff_crit;
    level_t        cand;
    logic [CW-1:0] cnt_upd;

    // Threshold lowered by HYST, clamped at zero instead of wrapping.
    function automatic logic [W-1:0] hyst_lower(input logic [W-1:0] thr);
        if (32'(thr) >= HYST)
            return W'(32'(thr) - HYST);
        else
            return '0;
    endfunction

    always_comb begin
        eff_prev = is_alert(state_reg) ? hyst_lower(prevent_thr) : prevent_thr;
        eff_crit = (state_reg == LVL_CRITICAL) ? hyst_lower(critical_thr) : critical_thr;

        // Critical checked first so it wins when its threshold is not above preventive.
        if (temp >= eff_crit)
            cand = LVL_CRITICAL;
        else if (temp >= eff_prev)
            cand = LVL_PREVENT;
        else
            cand = LVL_NORMAL;
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        cnt_next     = cnt_reg;
        cnt_upd      = cnt_reg;

        if (sample_valid) begin
            if (cand == state_reg) begin
                pending_next = LVL_NORMAL;
                cnt_next     = '0;
            end else begin
                if (cand == pending_reg) begin
                    cnt_upd = cnt_reg + CW'(1);
                end else begin
                    pending_next = cand;
                    cnt_upd      = CW'(1);
                end

                if (cnt_upd == CNT_MAX) begin
                    state_next = pending_next;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_upd;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= LVL_NORMAL;
            pending_reg  <= LVL_NORMAL;
            cnt_reg      <= '0;
            prevent_reg  <= 1'b0;
            critical_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            cnt_reg      <= cnt_next;
            prevent_reg  <= is_alert(state_next);
            critical_reg <= (state_next == LVL_CRITICAL);
        end
    end

    assign prevent           = prevent_reg;
    assign critical          = critical_reg;
    assign in_critical       = (state_reg == LVL_CRITICAL);
    assign entering_critical = (state_next == LVL_CRITICAL) && (state_reg != LVL_CRITICAL);

endmodule

// File: rtl/temp_level_monitor.sv
// Multi-channel temperature level monitor: one filter FSM per channel plus a
// sticky alarm that latches whenever any channel enters CRITICAL.
module temp_level_monitor
    import temp_level_monitor_pkg::*;
#(
    parameter int          W        = 5,
    parameter int          CHANNELS = 2,
    parameter int          PERSIST  = 3,
    parameter int unsigned HYST     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [CHANNELS*W-1:0] temp,
    input  logic [W-1:0]          prevent_thr,
    input  logic [W-1:0]          critical_thr,
    input  logic                  clear_alarm,
    output logic [CHANNELS-1:0]   prevent,
    output logic [CHANNELS-1:0]   critical,
    output logic                  alarm_sticky
);

    logic [CHANNELS-1:0] in_crit_vec;
    logic [CHANNELS-1:0] enter_crit_vec;
    logic                alarm_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            temp_level_channel #(
                .W       (W),
                .PERSIST (PERSIST),
                .HYST    (HYST)
            ) u_chan (
                .clk               (clk),
                .reset             (reset),
                .sample_valid      (sample_valid),
                .temp              (temp[gi*W +: W]),
                .prevent_thr       (prevent_thr),
                .critical_thr      (critical_thr),
                .prevent           (prevent[gi]),
                .critical          (critical[gi]),
                .in_critical       (in_crit_vec[gi]),
                .entering_critical (enter_crit_vec[gi])
            );
        end
    endgenerate

    // A channel currently in CRITICAL blocks the clear; a new entry overrides it.
    always_ff @(posedge clk) begin
        if (reset)
            alarm_reg <= 1'b0;
        else if (|enter_crit_vec)
            alarm_reg <= 1'b1;
        else if (clear_alarm && !(|in_crit_vec))
            alarm_reg <= 1'b0;
    end

    assign alarm_sticky = alarm_reg;

endmodule

// File: tb/tb_temp_level_monitor.sv
// Scoreboard bench for temp_level_monitor: a behavioural model predicts the outputs
// after every clock edge, and a negedge monitor compares them against the DUT.
module tb_temp_level_monitor;

    localparam int W        = 5;
    localparam int CHANNELS = 2;
    localparam int PERSIST  = 3;
    localparam int HYST     = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  sample_valid;
    logic [CHANNELS*W-1:0] temp;
    logic [W-1:0]          prevent_thr;
    logic [W-1:0]          critical_thr;
    logic                  clear_alarm;
    logic [CHANNELS-1:0]   prevent;
    logic [CHANNELS-1:0]   critical;
    logic                  alarm_sticky;

    temp_level_monitor #(
        .W        (W),
        .CHANNELS (CHANNELS),
        .PERSIST  (PERSIST),
        .HYST     (HYST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .temp         (temp),
        .prevent_thr  (prevent_thr),
        .critical_thr (critical_thr),
        .clear_alarm  (clear_alarm),
        .prevent      (prevent),
        .critical     (critical),
        .alarm_sticky (alarm_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] prev;
        logic [1:0] crit;
        logic       alarm;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // reference model state
    int m_state[CHANNELS];
    int m_cnt[CHANNELS];
    int m_pend[CHANNELS];
    bit m_alarm;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat0(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic int model_cand(input int s, input int t);
        int ep, ec;
        ep = (s >= 1) ? sat0(int'(prevent_thr) - HYST) : int'(prevent_thr);
        ec = (s >= 2) ? sat0(int'(critical_thr) - HYST) : int'(critical_thr);
        if (t >= ec) return 2;
        if (t >= ep) return 1;
        return 0;
    endfunction

    task automatic model_edge(input bit rst, input bit v, input int t0, input int t1, input bit clr);
        int  t[CHANNELS];
        bit  was_crit, enter;
        int  c;
        t[0] = t0;
        t[1] = t1;
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_state[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
            end
            m_alarm = 0;
            return;
        end
        was_crit = 0;
        enter    = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (m_state[i] == 2) was_crit = 1;
            if (v) begin
                c = model_cand(m_state[i], t[i]);
                if (c == m_state[i]) begin
                    m_cnt[i] = 0; m_pend[i] = 0;
                end else begin
                    if (c == m_pend[i]) m_cnt[i]++;
                    else begin m_pend[i] = c; m_cnt[i] = 1; end
                    if (m_cnt[i] == PERSIST) begin
                        if (m_pend[i] == 2) enter = 1;
                        m_state[i] = m_pend[i];
                        m_cnt[i]   = 0;
                    end
                end
            end
        end
        if (enter) m_alarm = 1;
        else if (clr && !was_crit) m_alarm = 0;
    endtask

    // Drive one cycle of inputs, then record the model's prediction for that edge.
    task automatic step(input string tag, input bit v, input int t0, input int t1,
                        input bit clr = 0, input bit rst = 0);
        exp_t e;
        reset        = rst;
        sample_valid = v;
        temp         = {W'(t1), W'(t0)};
        clear_alarm  = clr;
        @(posedge clk);
        model_edge(rst, v, t0, t1, clr);
        e.tag   = tag;
        e.alarm = m_alarm;
        for (int i = 0; i < CHANNELS; i++) begin
            e.prev[i] = (m_state[i] != 0);
            e.crit[i] = (m_state[i] == 2);
        end
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val({e.tag, ".prevent"},  32'(prevent),      32'(e.prev));
            check_val({e.tag, ".critical"}, 32'(critical),     32'(e.crit));
            check_val({e.tag, ".alarm"},    32'(alarm_sticky), 32'(e.alarm));
        end
    end

    task automatic to_normal(input string tag);
        for (int i = 0; i < 3; i++) step(tag, 1, 5, 5);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        temp         = '0;
        clear_alarm  = 1'b0;
        prevent_thr  = 5'd20;
        critical_thr = 5'd26;

        step("reset0", 1, 30, 30, 1, 1);
        step("reset1", 0, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) step("prev_up", 1, 21, 10);
        for (int i = 0; i < 3; i++) step("hyst_hold", 1, 19, 10);
        for (int i = 0; i < 3; i++) step("hyst_drop", 1, 17, 10);

        begin
            int seq[6] = '{21, 21, 15, 21, 21, 21};
            foreach (seq[i]) step("glitch", 1, seq[i], 10);
            to_normal("glitch_rst");
            foreach (seq[i]) begin
                step("gap_idle", 0, 0, 0);
                step("gap", 1, seq[i], 10);
                step("gap_idle", 0, 31, 31);
            end
            to_normal("gap_rst");
        end

        for (int i = 0; i < 3; i++) step("crit_up", 1, 10, 30);
        step("clr_in_crit", 0, 10, 30, 1);
        step("hold_crit", 0, 0, 0);
        for (int i = 0; i < 3; i++) step("crit_down", 1, 10, 5);
        step("clr_normal", 0, 10, 5, 1);
        step("after_clr", 0, 10, 5);

        step("rst_mid", 1, 21, 10);
        step("rst_mid", 1, 21, 10);
        step("rst_pulse", 1, 21, 10, 0, 1);
        step("rst_after1", 1, 21, 10);
        step("rst_after2", 1, 21, 10);
        step("rst_after3", 1, 21, 10);
        to_normal("rst_done");

        // Randomised traffic near the thresholds, including inverted threshold pairs.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 40) == 0) begin
                prevent_thr  = 5'($urandom_range(10, 25));
                critical_thr = 5'($urandom_range(12, 31));
            end
            step("rand", ($urandom_range(0, 3) != 0),
                 int'($urandom_range(12, 31)), int'($urandom_range(12, 31)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
        end

        repeat (3) @(negedge clk);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/temp_level_monitor.md
TEMP_LEVEL_MONITOR -- requirements
Module: temp_level_monitor

Interface
REQ-001 SHALL have parameter W, default 5, temperature code width in bits.
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent sensor channels.
REQ-003 SHALL have parameter PERSIST, default 3, consecutive qualifying samples needed for a level change; legal range is PERSIST >= 1.
REQ-004 SHALL have parameter HYST, default 2, hysteresis in code units applied to downward transitions.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sample_valid  input  1  temp bus holds a new sample this cycle.
REQ-008 SHALL have port temp  input  CHANNELS*W  packed per-channel codes; channel i occupies bits [i*W +: W].
REQ-009 SHALL have port prevent_thr  input  W  preventive threshold.
REQ-010 SHALL have port critical_thr  input  W  critical threshold.
REQ-011 SHALL have port clear_alarm  input  1  request to clear the sticky alarm.
REQ-012 SHALL have port prevent  output  CHANNELS  bit i is high while channel i is in PREVENT or CRITICAL.
REQ-013 SHALL have port critical  output  CHANNELS  bit i is high while channel i is in CRITICAL.
REQ-014 SHALL have port alarm_sticky  output  1  latched "some channel reached CRITICAL".

Function
REQ-015 Each channel SHALL run an FSM with states NORMAL(0), PREVENT(1) and CRITICAL(2).
REQ-016 All inputs and thresholds SHALL be treated as unsigned, and all comparisons SHALL be >=.
REQ-017 Effective thresholds in state S:
- A level k > S uses its threshold unchanged.
- A level k <= S uses thr_k - HYST, saturating at 0.
REQ-018 Candidate level C SHALL be the highest level whose effective threshold temp meets, or 0 if none is met.
REQ-019 If critical_thr <= prevent_thr, CRITICAL SHALL dominate the result.
REQ-020 On a cycle with sample_valid=1 and C == S, the channel counter and pending register SHALL clear.
REQ-021 On a cycle with sample_valid=1 and C != S:
- If C == pending, the counter SHALL increment.
- Otherwise pending SHALL load C and the counter SHALL load 1.
REQ-022 When the counter value after the update equals PERSIST, the state SHALL load pending and the counter SHALL clear in the same edge.
- Multi-level jumps such as NORMAL to CRITICAL or CRITICAL to NORMAL SHALL be allowed.
REQ-023 On a cycle with sample_valid=0, the state, counter and pending register SHALL hold.
REQ-024 The counter SHALL be clog2(PERSIST+1) bits wide and SHALL never exceed PERSIST.
REQ-025 prevent and critical SHALL be registered and decoded from state only.
- They SHALL change on the clock edge that samples the PERSIST-th qualifying sample, so they are visible the following cycle.
REQ-026 alarm_sticky SHALL set on any edge where any channel enters CRITICAL.
REQ-027 alarm_sticky SHALL clear on clear_alarm=1 only when no channel is or is entering CRITICAL; set SHALL dominate clear.
REQ-028 Channels SHALL be fully independent, with no shared counters.
REQ-029 Threshold changes SHALL take effect on the next valid sample without flushing the counters.

Reset
REQ-030 On reset=1 at a clock edge, all channels SHALL go to NORMAL with counter=0 and pending=0.
REQ-031 On the same reset edge, prevent and critical SHALL go to all-zero and alarm_sticky SHALL go to 0.
REQ-032 Reset SHALL dominate sample_valid and clear_alarm, and SHALL abort any partial persistence count.

Structure
REQ-033 A shared package SHALL hold the level encoding constants (LVL_NORMAL, LVL_PREVENT, LVL_CRITICAL) and the 2-bit level typedef.
REQ-034 Per-channel logic SHALL live in one sub-module, temp_level_channel, instantiated CHANNELS times by a generate loop.
REQ-035 The top level SHALL contain only the sticky alarm logic and the output packing.

Verification
(Bench settings: W=5, CHANNELS=2, PERSIST=3, HYST=2, prevent_thr=20, critical_thr=26.)
REQ-036 Ch0 temp=21 on three valid samples, ch1=10 -> prevent=2'b01 from the cycle after the third sample, critical=0, alarm_sticky=0.
REQ-037 Ch0 in PREVENT; temp=19 x3 -> stays PREVENT; then temp=17 x3 -> prevent[0]=0 after the third sample.
REQ-038 Glitch: ch0 sequence 21,21,15,21,21 -> prevent[0] stays 0; the next 21 sets it.
REQ-039 Valid-gap test: the same sequence interleaved with sample_valid=0 cycles -> identical result.
REQ-040 Ch1 temp=30 x3 from NORMAL:
- critical=2'b10 and prevent=2'b10, alarm_sticky=1.
- clear_alarm while CRITICAL -> alarm_sticky stays 1.
- After ch1 drops to NORMAL (temp=5 x3), clear_alarm -> alarm_sticky=0 next cycle.
REQ-041 Reset mid-count: two samples of 21, then reset=1 for one cycle, then one sample of 21 -> outputs 0; two further samples of 21 are required before prevent[0]=1.
